// File: rtl/axis_rd_playout_buf.sv
// Playout buffer between the MM2S read stream and the DAC path: FWFT FIFO with prefill
// threshold, continuous play, zero-fill and underflow accounting when the FIFO runs dry.
module axis_rd_playout_buf #(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned PREFILL = 32
) (
  input  logic                      axi_aclk,
  input  logic                      axi_rstb,
  input  logic [DATA_W-1:0]         s_axis_tdata,
  input  logic [DATA_W/8-1:0]       s_axis_tkeep,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [DATA_W-1:0]         m_dac_tdata,
  output logic                      m_dac_tvalid,
  input  logic                      m_dac_tready,
  input  logic                      play_en,
  input  logic                      read_reset,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [1:0]                state,
  output logic                      underflow,
  output logic [15:0]               underflow_cnt,
  output logic [15:0]               frame_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned KW = DATA_W / 8;
  localparam logic [AW:0] LvlFull    = LW'(DEPTH);
  localparam logic [AW:0] LvlPrefill = LW'(PREFILL);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StPrefill = 2'b01,
    StPlay    = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         level_q;
  logic                underflow_q;
  logic [15:0]         uf_cnt_q;
  logic [15:0]         frame_cnt_q;
  logic [DATA_W-1:0]   wr_data;
  logic                empty, full, push, pop, uf_evt;

  assign empty  = (level_q == '0);
  assign full   = (level_q == LvlFull);

  assign s_axis_tready = (state_q != StIdle) && !full;
  assign m_dac_tvalid  = (state_q == StPlay);

  assign push   = s_axis_tvalid && s_axis_tready;
  assign pop    = m_dac_tvalid && m_dac_tready && !empty;
  assign uf_evt = m_dac_tvalid && m_dac_tready && empty;

  // Head word falls through; zero whenever there is nothing valid to show.
  assign m_dac_tdata = (m_dac_tvalid && !empty) ? mem_q[rd_ptr_q] : '0;

  assign fifo_level    = level_q;
  assign state         = state_q;
  assign underflow     = underflow_q;
  assign underflow_cnt = uf_cnt_q;
  assign frame_cnt     = frame_cnt_q;

  always_comb begin
    wr_data = '0;
    for (int b = 0; b < KW; b++) begin
      wr_data[b*8 +: 8] = s_axis_tkeep[b] ? s_axis_tdata[b*8 +: 8] : 8'h00;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!play_en) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:    state_d = StPrefill;
        StPrefill: if (level_q >= LvlPrefill) state_d = StPlay;
        StPlay:    state_d = StPlay;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_rstb || read_reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
      uf_cnt_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      // Dropping play_en flushes the FIFO on the same edge; counters survive.
      if (!play_en) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        if (push && !pop)      level_q <= level_q + LW'(1);
        else if (pop && !push) level_q <= level_q - LW'(1);
      end
      if (push && s_axis_tlast) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (uf_evt) begin
        underflow_q <= 1'b1;
        if (uf_cnt_q != 16'hFFFF) uf_cnt_q <= uf_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
